register_file: RTL

Parametrised multi-entry register file built on the same load/reset semantics as the single register it succeeds. It holds `2**k` words of `n` bits and offers one write port and two asynchronous read ports. Optional write-to-read bypass and a hardwired-zero register 0 are available. A shadow bank supports single-cycle checkpoint (save) and rollback (restore). It sits between the datapath's writeback stage and the operand-fetch logic.

---
 rtl/register_file.sv | 135 +++++++++++++
 1 files changed

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// Multi-entry register file between the writeback stage and operand fetch.
// Holds 2**k words of n bits, one synchronous write port and two combinational
// read ports. A shadow bank gives single-cycle checkpoint (save) and rollback
// (restore); save together with restore swaps the two banks.
//
// Parameters
//   n         word width in bits
//   k         address width, depth = 2**k
//   ZERO_REG  1: entry 0 is hardwired to zero (reads, writes, save, restore)
//   BYPASS    1: a read of the address being written returns write_data
//
// Ports
//   clock           in   rising-edge clock
//   reset           in   asynchronous, active-high; zeroes main and shadow
//   write_enable    in   write write_data to write_address at the next edge
//   write_address   in   [k-1:0] write target
//   write_data      in   [n-1:0] write value
//   read_address_a  in   [k-1:0] port A address
//   read_data_a     out  [n-1:0] port A data, combinational
//   read_address_b  in   [k-1:0] port B address
//   read_data_b     out  [n-1:0] port B data, combinational
//   clear           in   synchronous clear of the main bank only
//   save            in   copy main bank into shadow bank
//   restore         in   copy shadow bank into main bank
// -----------------------------------------------------------------------------
module register_file #(
  parameter int n        = 8,
  parameter int k        = 3,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         write_enable,
  input  logic [k-1:0] write_address,
  input  logic [n-1:0] write_data,
  input  logic [k-1:0] read_address_a,
  output logic [n-1:0] read_data_a,
  input  logic [k-1:0] read_address_b,
  output logic [n-1:0] read_data_b,
  input  logic         clear,
  input  logic         save,
  input  logic         restore
);

  localparam int DEPTH = 2 ** k;

  logic [n-1:0] r_main   [DEPTH];
  logic [n-1:0] r_shadow [DEPTH];

  logic w_write_ok;
  logic w_bypass_ok;
  logic w_zero_a;
  logic w_zero_b;
  logic w_hit_a;
  logic w_hit_b;

  // A write to the hardwired zero entry is discarded here, so entry 0 of the
  // main bank never leaves 0 and the shadow copy of it stays 0 as well.
  assign w_write_ok = write_enable && !(ZERO_REG && (write_address == '0));

  // Bypass only forwards writes that will actually land at the next edge:
  // clear and restore drop the write, and reset overrides everything.
  assign w_bypass_ok = BYPASS && write_enable && !clear && !restore && !reset;

  assign w_zero_a = ZERO_REG && (read_address_a == '0);
  assign w_zero_b = ZERO_REG && (read_address_b == '0);
  assign w_hit_a  = w_bypass_ok && (read_address_a == write_address);
  assign w_hit_b  = w_bypass_ok && (read_address_b == write_address);

  // Main and shadow banks share one process so that save captures the
  // pre-edge main values even when clear, restore or a write happen in the
  // same cycle (non-blocking reads of r_main see the old contents).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_main[i]   <= '0;
        r_shadow[i] <= '0;
      end
    end else begin
      if (clear) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_main[i] <= '0;
        end
      end else if (restore) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ZERO_REG && (i == 0)) begin
            r_main[i] <= '0;
          end else begin
            r_main[i] <= r_shadow[i];
          end
        end
      end else if (w_write_ok) begin
        r_main[write_address] <= write_data;
      end

      if (save) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ZERO_REG && (i == 0)) begin
            r_shadow[i] <= '0;
          end else begin
            r_shadow[i] <= r_main[i];
          end
        end
      end
    end
  end

  // Read precedence: reset and the zero entry force 0, then bypass, then the
  // stored word. The storage is already 0 during reset; gating on reset
  // keeps bypass from leaking write_data while reset is held.
  always_comb begin
    read_data_a = r_main[read_address_a];
    if (w_hit_a) begin
      read_data_a = write_data;
    end
    if (reset || w_zero_a) begin
      read_data_a = '0;
    end
  end

  always_comb begin
    read_data_b = r_main[read_address_b];
    if (w_hit_b) begin
      read_data_b = write_data;
    end
    if (reset || w_zero_b) begin
      read_data_b = '0;
    end
  end

endmodule
